// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the RV32I datapath.
// The slave side is the control unit; the master side is the datapath/IR.
interface multicycle_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic       illegal_op;
  logic [3:0] state_dbg;

  modport slave (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, RegWrite, ImmSrc, illegal_op, state_dbg
  );

  modport master (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, RegWrite, ImmSrc, illegal_op, state_dbg
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for a multicycle RV32I subset core, with embedded ALU decoder.
// Outputs decode from the state register; write enables are gated off during reset.
module multicycle_control_fsm #(
  parameter logic [6:0] OP_LW  = 7'b0000011,
  parameter logic [6:0] OP_SW  = 7'b0100011,
  parameter logic [6:0] OP_R   = 7'b0110011,
  parameter logic [6:0] OP_I   = 7'b0010011,
  parameter logic [6:0] OP_BEQ = 7'b1100011,
  parameter logic [6:0] OP_JAL = 7'b1101111
) (
  input  logic                          clk,
  input  logic                          rst_n,
  multicycle_control_fsm_if.slave       ctrl_if
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  state_e     state_q, state_d;
  logic       pc_update, branch, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       is_alu_op, funct3_ok;

  assign is_alu_op = (ctrl_if.op == OP_R) || (ctrl_if.op == OP_I);
  assign funct3_ok = ctrl_if.funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target oldPC + imm while the op decodes
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (ctrl_if.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
        if (is_alu_op && !funct3_ok) illegal = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (ctrl_if.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: reg_write = 1'b1;
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (ctrl_if.funct3)
          // only R-type (op[5]=1) turns funct7b5 into a subtract
          3'b000:  alu_control = (ctrl_if.op[5] & ctrl_if.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  always_comb begin
    case (ctrl_if.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign ctrl_if.PCWrite    = (pc_update | (branch & ctrl_if.zero)) & rst_n;
  assign ctrl_if.AdrSrc     = adr_src;
  assign ctrl_if.MemWrite   = mem_write & rst_n;
  assign ctrl_if.IRWrite    = ir_write & rst_n;
  assign ctrl_if.ResultSrc  = result_src;
  assign ctrl_if.ALUSrcA    = alu_src_a;
  assign ctrl_if.ALUSrcB    = alu_src_b;
  assign ctrl_if.ALUControl = alu_control;
  assign ctrl_if.RegWrite   = reg_write & rst_n;
  assign ctrl_if.ImmSrc     = imm_src;
  assign ctrl_if.illegal_op = illegal & rst_n;
  assign ctrl_if.state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: per-cycle expected control words
// are queued per instruction and checked one cycle at a time.
module tb_multicycle_control_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;

  typedef struct {
    logic        rn;
    logic [20:0] exp;
    string       tag;
  } entry_t;

  logic   clk;
  logic   rst_n;
  int     n_cmp;
  int     n_fail;
  entry_t sbq[$];

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference control word: {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
  // ALUSrcA, ALUSrcB, ALUControl, RegWrite, ImmSrc, illegal_op}
  function automatic logic [20:0] model(input logic [3:0] st, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7,
                                        input logic z, input logic rn);
    logic       pcu, br, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb, aop, imm;
    logic [2:0] ac;
    logic       legal_op, legal_f3;
    pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00; imm = 2'b00; ac = 3'b000;
    legal_op = (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BEQ) || (o == JAL);
    legal_f3 = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    case (st)
      4'd0:  begin irw = 1; sb = 2'b10; rs = 2'b10; pcu = 1; end
      4'd1:  begin sa = 2'b01; sb = 2'b01; ill = !legal_op || (((o == RT) || (o == IT)) && !legal_f3); end
      4'd2:  begin sa = 2'b10; sb = 2'b01; end
      4'd3:  adr = 1;
      4'd4:  begin rs = 2'b01; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin sa = 2'b10; aop = 2'b10; end
      4'd7:  rw = 1;
      4'd8:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      4'd9:  begin sa = 2'b01; sb = 2'b10; pcu = 1; end
      4'd10: begin sa = 2'b10; aop = 2'b01; br = 1; end
      default: ;
    endcase
    if (aop == 2'b01) ac = 3'b001;
    else if (aop == 2'b10) begin
      if (f3 == 3'b000)      ac = (o[5] && f7) ? 3'b001 : 3'b000;
      else if (f3 == 3'b010) ac = 3'b101;
      else if (f3 == 3'b110) ac = 3'b011;
      else if (f3 == 3'b111) ac = 3'b010;
    end
    if (o == SW)       imm = 2'b01;
    else if (o == BEQ) imm = 2'b10;
    else if (o == JAL) imm = 2'b11;
    return {st, (pcu | (br & z)) & rn, adr, mw & rn, irw & rn, rs, sa, sb, ac,
            rw & rn, imm, ill & rn};
  endfunction

  // seq lists states left-to-right as nibbles; rmask gives rst_n per cycle, MSB first
  task automatic run(input string name, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic [31:0] seq,
                     input logic [7:0] rmask, input int n);
    entry_t      e;
    logic [20:0] obs;
    bus.op = o;
    bus.funct3 = f3;
    bus.funct7b5 = f7;
    bus.zero = z;
    for (int i = 0; i < n; i++) begin
      e.rn  = rmask[7-i];
      e.exp = model(seq[4*(7-i) +: 4], o, f3, f7, z, e.rn);
      e.tag = $sformatf("%s_c%0d", name, i);
      sbq.push_back(e);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      rst_n = e.rn;
      #1;
      obs = {bus.state_dbg, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
             bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.RegWrite,
             bus.ImmSrc, bus.illegal_op};
      n_cmp++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
      @(negedge clk);
    end
    $display("txn %-10s op=%b funct3=%b f7b5=%b zero=%b cycles=%0d", name, o, f3, f7, z, n);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.op = LW;
    bus.funct3 = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.zero = 1'b0;
    repeat (2) @(negedge clk);

    run("reset_lw",  LW,      3'b010, 1'b0, 1'b0, 32'h00123400, 8'b01111100, 6);
    run("sw",        SW,      3'b010, 1'b0, 1'b0, 32'h01250000, 8'b11110000, 4);
    run("r_sub",     RT,      3'b000, 1'b1, 1'b0, 32'h01670000, 8'b11110000, 4);
    run("r_add",     RT,      3'b000, 1'b0, 1'b0, 32'h01670000, 8'b11110000, 4);
    run("r_slt",     RT,      3'b010, 1'b0, 1'b0, 32'h01670000, 8'b11110000, 4);
    run("r_or",      RT,      3'b110, 1'b0, 1'b0, 32'h01670000, 8'b11110000, 4);
    run("r_and",     RT,      3'b111, 1'b1, 1'b0, 32'h01670000, 8'b11110000, 4);
    run("i_add",     IT,      3'b000, 1'b1, 1'b0, 32'h01870000, 8'b11110000, 4);
    run("jal",       JAL,     3'b000, 1'b0, 1'b1, 32'h01970000, 8'b11110000, 4);
    run("beq_taken", BEQ,     3'b000, 1'b0, 1'b1, 32'h01A00000, 8'b11100000, 3);
    run("beq_not",   BEQ,     3'b000, 1'b0, 1'b0, 32'h01A00000, 8'b11100000, 3);
    run("illegal",   7'h7F,   3'b000, 1'b0, 1'b0, 32'h01000000, 8'b11000000, 2);
    run("r_badf3",   RT,      3'b001, 1'b0, 1'b0, 32'h01670000, 8'b11110000, 4);
    run("lw_midrst", LW,      3'b010, 1'b0, 1'b0, 32'h01234000, 8'b11110000, 6);
    run("lw",        LW,      3'b010, 1'b0, 1'b1, 32'h01234000, 8'b11111000, 5);
    run("end",       IT,      3'b110, 1'b0, 1'b0, 32'h00000000, 8'b10000000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
